// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : shared VGA widths, timing-bus packing and 1024x768@60 constants |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package vga_pkg;

    localparam int RGB_W   = 12;
    localparam int COORD_W = 11;
    localparam int BOUND_W = COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] vcount;
        logic               vsync;
        logic               vblnk;
        logic [COORD_W-1:0] hcount;
        logic               hsync;
        logic               hblnk;
    } vga_tbus_t;

    localparam int TBUS_W = $bits(vga_tbus_t);

    localparam int H_ACTIVE     = 1024;
    localparam int H_SYNC_START = 1048;
    localparam int H_SYNC_END   = 1184;
    localparam int V_ACTIVE     = 768;
    localparam int V_SYNC_START = 771;
    localparam int V_SYNC_END   = 777;

    // Bounds are widened by one bit so a sprite hanging past coordinate 2047 never wraps.
    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input int                 len);
        logic [BOUND_W-1:0] v_x;
        logic [BOUND_W-1:0] lo_x;
        logic [BOUND_W-1:0] hi_x;
        v_x  = {1'b0, v};
        lo_x = {1'b0, lo};
        hi_x = lo_x + BOUND_W'(len - 1);
        return (v_x >= lo_x) && (v_x <= hi_x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_sprite_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_line : resettable shift-register delay, DEPTH=0 collapses to a wire |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_clk;
            assign w_unused_clk = pclk ^ rst_n;
            assign q_o          = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] taps_q [DEPTH];

            always_ff @(posedge pclk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        taps_q[i] <= '0;
                    end
                end else begin
                    taps_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps_q[i] <= taps_q[i-1];
                    end
                end
            end

            assign q_o = taps_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | draw_sprite : per-frame latched sprite overlay on the VGA timing chain.   |
// | Optional macro DRAW_SPRITE_TRANSP_EN enables TRANSP_COLOR keying. Rev 1.0 |
// +--------------------------------------------------------------------------+
module draw_sprite
    import vga_pkg::*;
#(
    parameter int          SPRITE_W     = 48,
    parameter int          SPRITE_H     = 64,
    parameter int          ADDR_W       = 12,
    parameter int          ROM_LATENCY  = 1,
    parameter logic [11:0] TRANSP_COLOR = 12'hF0F
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               sprite_en,
    input  logic [COORD_W-1:0] vcount_in,
    input  logic               vsync_in,
    input  logic               vblnk_in,
    input  logic [COORD_W-1:0] hcount_in,
    input  logic               hsync_in,
    input  logic               hblnk_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [RGB_W-1:0]   rgb_pixel,
    output logic [COORD_W-1:0] vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic [COORD_W-1:0] hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic [RGB_W-1:0]   rgb_out,
    output logic [ADDR_W-1:0]  pixel_addr
);

    localparam int                DL_W       = TBUS_W + RGB_W + 1;
    localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] c_ROW_LAST = ADDR_W'((SPRITE_H - 1) * SPRITE_W);

    logic               vblnk_prev_q;
    logic               hblnk_prev_q;
    logic [COORD_W-1:0] xpos_l_q;
    logic [COORD_W-1:0] ypos_l_q;
    logic               en_l_q;
    logic [ADDR_W-1:0]  row_base_q;
    logic [ADDR_W-1:0]  pixel_addr_q;
    logic [ADDR_W-1:0]  pixel_addr_d;
    logic               in_rect_q;
    logic               in_rect_d;
    vga_tbus_t          s1_bus_q;
    logic [RGB_W-1:0]   s1_rgb_q;
    vga_tbus_t          out_bus_q;
    logic [RGB_W-1:0]   rgb_out_q;
    logic [RGB_W-1:0]   rgb_out_d;

    vga_tbus_t          w_bus_in;
    vga_tbus_t          w_dl_bus;
    logic [RGB_W-1:0]   w_dl_rgb;
    logic               w_dl_in_rect;
    logic [DL_W-1:0]    w_dl_d;
    logic [DL_W-1:0]    w_dl_q;
    logic               w_vblnk_rise;
    logic               w_hblnk_rise;
    logic               w_in_rows;
    logic               w_show_sprite;
    logic [COORD_W-1:0] w_col;

    assign w_bus_in     = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in};
    assign w_vblnk_rise = vblnk_in & ~vblnk_prev_q;
    assign w_hblnk_rise = hblnk_in & ~hblnk_prev_q;
    assign w_in_rows    = in_span(vcount_in, ypos_l_q, SPRITE_H);
    assign in_rect_d    = en_l_q & ~(vblnk_in | hblnk_in) & w_in_rows
                        & in_span(hcount_in, xpos_l_q, SPRITE_W);
    assign w_col        = hcount_in - xpos_l_q;
    assign pixel_addr_d = in_rect_d ? (row_base_q + ADDR_W'(w_col)) : pixel_addr_q;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            hblnk_prev_q <= 1'b0;
            xpos_l_q     <= '0;
            ypos_l_q     <= '0;
            en_l_q       <= 1'b0;
            row_base_q   <= '0;
            in_rect_q    <= 1'b0;
            pixel_addr_q <= '0;
            s1_bus_q     <= '0;
            s1_rgb_q     <= '0;
            out_bus_q    <= '0;
            rgb_out_q    <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            hblnk_prev_q <= hblnk_in;
            if (w_vblnk_rise) begin
                xpos_l_q   <= xpos;
                ypos_l_q   <= ypos;
                en_l_q     <= sprite_en;
                row_base_q <= '0;
            end else if (w_hblnk_rise && w_in_rows && (row_base_q != c_ROW_LAST)) begin
                // Advancing per scanline (not per drawn pixel) keeps clipped rows address-correct.
                row_base_q <= row_base_q + c_ROW_STEP;
            end
            in_rect_q    <= in_rect_d;
            pixel_addr_q <= pixel_addr_d;
            s1_bus_q     <= w_bus_in;
            s1_rgb_q     <= rgb_in;
            out_bus_q    <= w_dl_bus;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign w_dl_d = {s1_bus_q, s1_rgb_q, in_rect_q};

    delay_line #(
        .WIDTH (DL_W),
        .DEPTH (ROM_LATENCY)
    ) u_align (
        .pclk  (pclk),
        .rst_n (rst_n),
        .d_i   (w_dl_d),
        .q_o   (w_dl_q)
    );

    assign {w_dl_bus, w_dl_rgb, w_dl_in_rect} = w_dl_q;

`ifdef DRAW_SPRITE_TRANSP_EN
    assign w_show_sprite = w_dl_in_rect && (rgb_pixel != TRANSP_COLOR);
`else
    logic w_unused_key;
    assign w_unused_key  = ^TRANSP_COLOR;
    assign w_show_sprite = w_dl_in_rect;
`endif

    assign rgb_out_d = (w_dl_bus.vblnk | w_dl_bus.hblnk) ? '0
                     : (w_show_sprite ? rgb_pixel : w_dl_rgb);

    assign vcount_out = out_bus_q.vcount;
    assign vsync_out  = out_bus_q.vsync;
    assign vblnk_out  = out_bus_q.vblnk;
    assign hcount_out = out_bus_q.hcount;
    assign hsync_out  = out_bus_q.hsync;
    assign hblnk_out  = out_bus_q.hblnk;
    assign rgb_out    = rgb_out_q;
    assign pixel_addr = pixel_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
// tb_draw_sprite : scoreboard + probe-table bench for draw_sprite on shortened, hand-driven frames.
module tb_draw_sprite;
    import vga_pkg::*;

    localparam int          W       = 48;
    localparam int          H       = 64;
    localparam int          AW      = 12;
    localparam int          LAT     = 1;
    localparam int          OUT_LAT = LAT + 2;
    localparam logic [11:0] KEY     = 12'hF0F;
`ifdef DRAW_SPRITE_TRANSP_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] xpos, ypos, vcount_in, hcount_in;
    logic        sprite_en, vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in, rgb_pixel;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;
    logic [AW-1:0] pixel_addr;

    always #5 pclk = ~pclk;

    draw_sprite #(
        .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(AW), .ROM_LATENCY(LAT), .TRANSP_COLOR(KEY)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .sprite_en(sprite_en),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .rgb_pixel(rgb_pixel),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .pixel_addr(pixel_addr)
    );

    typedef struct { int due; logic [37:0] val; } exp_t;
    typedef struct { int due; logic [11:0] val; } addr_t;
    typedef struct { int due; int idx; bit is_rgb; logic [11:0] val; } probe_t;
    typedef struct { int phase; int h; int v; bit chk_addr; int addr; bit chk_rgb; logic [11:0] rgb; } probe_rec_t;

    exp_t       exp_q[$];
    addr_t      addr_q[$];
    probe_t     probe_q[$];
    probe_rec_t tbl [14];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   phase = 0;
    bit   sb_on = 1'b0;
    bit   force_pix = 1'b0;
    bit   bg_const_on = 1'b0;
    logic [AW-1:0] addr_hist [8];

    int m_xl = 0, m_yl = 0, m_addr = 0;
    bit m_en = 1'b0, m_vb_prev = 1'b0;

    function automatic logic [11:0] rom(input logic [11:0] a);
        return a ^ 12'hA5C;
    endfunction

    function automatic logic [11:0] bg(input int h, input int v);
        return 12'(h * 7 + v * 13) | 12'h001;
    endfunction

    function automatic logic [37:0] dut_out();
        return {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out, rgb_out};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        exp_t   e;
        addr_t  a;
        probe_t p;
        @(posedge pclk);
        #1;
        cyc++;
        addr_hist[cyc % 8] = pixel_addr;
        rgb_pixel = force_pix ? KEY : rom(12'(addr_hist[(cyc + 8 - LAT) % 8]));
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("stream", 64'(dut_out()), 64'(e.val));
        end
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            a = addr_q.pop_front();
            check("pixel_addr", 64'(pixel_addr), 64'(a.val));
        end
        while (probe_q.size() > 0 && probe_q[0].due <= cyc) begin
            p = probe_q.pop_front();
            if (p.is_rgb) check($sformatf("probe%0d_rgb", p.idx), 64'(rgb_out), 64'(p.val));
            else          check($sformatf("probe%0d_addr", p.idx), 64'(pixel_addr), 64'(p.val));
        end
    endtask

    task automatic cycle(input int h, input int v, input bit hb, input bit vb);
        logic [11:0] bgv, pix, er;
        logic        hs, vs;
        bit          inr;
        bgv = bg_const_on ? 12'h123 : bg(h, v);
        hs  = (h >= H_SYNC_START) && (h < H_SYNC_END);
        vs  = (v >= V_SYNC_START) && (v < V_SYNC_END);
        hcount_in = 11'(h); vcount_in = 11'(v);
        hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs; rgb_in = bgv;
        if (sb_on) begin
            inr = m_en && !hb && !vb && h >= m_xl && h <= m_xl + W - 1 && v >= m_yl && v <= m_yl + H - 1;
            if (inr) m_addr = (v - m_yl) * W + (h - m_xl);
            if (vb && !m_vb_prev) begin
                m_xl = int'(xpos); m_yl = int'(ypos); m_en = sprite_en;
            end
            pix = force_pix ? KEY : rom(12'(m_addr));
            er  = (hb || vb) ? 12'h000 : (inr ? ((TRANSP && pix == KEY) ? bgv : pix) : bgv);
            exp_q.push_back('{cyc + OUT_LAT, {11'(v), vs, vb, 11'(h), hs, hb, er}});
            addr_q.push_back('{cyc + 1, 12'(m_addr)});
            for (int i = 0; i < 14; i++) begin
                if (tbl[i].phase == phase && tbl[i].h == h && tbl[i].v == v && !hb && !vb) begin
                    if (tbl[i].chk_addr) probe_q.push_back('{cyc + 1, i, 1'b0, 12'(tbl[i].addr)});
                    if (tbl[i].chk_rgb)  probe_q.push_back('{cyc + OUT_LAT, i, 1'b1, tbl[i].rgb});
                end
            end
        end
        m_vb_prev = sb_on ? vb : 1'b0;
        step();
    endtask

    task automatic line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cycle(h, v, 1'b0, 1'b0);
        repeat (4) cycle(H_ACTIVE, v, 1'b1, 1'b0);
    endtask

    task automatic vblank(input int n);
        repeat (n) cycle(0, V_ACTIVE, 1'b1, 1'b1);
    endtask

    task automatic model_reset();
        m_xl = 0; m_yl = 0; m_addr = 0; m_en = 1'b0; m_vb_prev = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 400,  680, 1'b1,    0, 1'b1, 12'hA5C};
        tbl[1]  = '{1, 447,  680, 1'b1,   47, 1'b1, 12'hA73};
        tbl[2]  = '{1, 400,  681, 1'b1,   48, 1'b1, 12'hA6C};
        tbl[3]  = '{1, 400,  700, 1'b1,  960, 1'b0, 12'h000};
        tbl[4]  = '{1, 447,  743, 1'b1, 3071, 1'b1, 12'h1A3};
        tbl[5]  = '{1, 448,  690, 1'b1,  527, 1'b1, 12'hF4B};
        tbl[6]  = '{2, 200,  680, 1'b1,    0, 1'b0, 12'h000};
        tbl[7]  = '{2, 247,  681, 1'b1,   95, 1'b0, 12'h000};
        tbl[8]  = '{3, 230,  682, 1'b1,    0, 1'b1, 12'h8ED};
        tbl[9]  = '{4, 1000,  10, 1'b1,    0, 1'b0, 12'h000};
        tbl[10] = '{4, 1023,  10, 1'b1,   23, 1'b0, 12'h000};
        tbl[11] = '{4, 1000,  11, 1'b1,   48, 1'b0, 12'h000};
        tbl[12] = '{4, 1005,  12, 1'b1,  101, 1'b1, TRANSP ? 12'h123 : 12'hF0F};
        tbl[13] = '{5, 420,  680, 1'b1,  106, 1'b1, 12'hE05};
        for (int i = 0; i < 8; i++) addr_hist[i] = '0;

        rst_n = 1'b0; xpos = '0; ypos = '0; sprite_en = 1'b0; rgb_pixel = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(10 + i, 5, 1'b0, 1'b0);
            check("reset_out", 64'(dut_out()), 64'd0);
            check("reset_addr", 64'(pixel_addr), 64'd0);
        end
        rst_n = 1'b1; sb_on = 1'b1; model_reset();

        phase = 1; xpos = 11'd400; ypos = 11'd680; sprite_en = 1'b1;
        vblank(4);
        for (int v = 679; v <= 744; v++) begin
            if (v == 700) xpos = 11'd200;
            line(v, 396, 451);
        end

        phase = 2;
        vblank(4);
        line(680, 196, 251);
        line(681, 196, 251);
        for (int h = 196; h <= 220; h++) cycle(h, 682, 1'b0, 1'b0);
        rst_n = 1'b0; sb_on = 1'b0;
        exp_q.delete(); addr_q.delete(); probe_q.delete();
        for (int i = 0; i < 5; i++) begin
            cycle(221 + i, 682, 1'b0, 1'b0);
            check("midreset_out", 64'(dut_out()), 64'd0);
            check("midreset_addr", 64'(pixel_addr), 64'd0);
        end
        rst_n = 1'b1; sb_on = 1'b1; model_reset();
        phase = 3;
        for (int h = 226; h <= 251; h++) cycle(h, 682, 1'b0, 1'b0);
        repeat (4) cycle(H_ACTIVE, 682, 1'b1, 1'b0);

        phase = 4; xpos = 11'd1000; ypos = 11'd10; sprite_en = 1'b1;
        vblank(4);
        line(10, 995, H_ACTIVE - 1);
        line(11, 995, H_ACTIVE - 1);
        bg_const_on = 1'b1; force_pix = 1'b1;
        line(12, 1000, 1010);
        bg_const_on = 1'b0; force_pix = 1'b0;

        phase = 5; xpos = 11'd400; ypos = 11'd680; sprite_en = 1'b0;
        vblank(4);
        line(680, 396, 451);
        line(681, 396, 451);

        sb_on = 1'b0;
        repeat (OUT_LAT + 3) cycle(0, V_ACTIVE, 1'b1, 1'b1);
        check("drain", 64'(exp_q.size() + addr_q.size() + probe_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
